// File: rtl/strobe_word_fifo.sv
// Strobe-captured word FIFO with valid/ready drain and sticky overflow flag.
// Optional STROBE_FIFO_OVF_CNT_EN adds an 8-bit saturating dropped-strobe counter.
module strobe_word_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  strobe,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  overflow,
   input  logic                  clr_ovf
`ifdef STROBE_FIFO_OVF_CNT_EN
   ,
   output logic [7:0]            ovf_cnt
`endif
);

   localparam int                DEPTH   = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] C_ZERO  = '0;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_ovf;

   logic                  w_full;
   logic                  w_valid;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [DEPTH_LOG2-1:0] w_rd_next;
   logic [DEPTH_LOG2:0]   w_after_pop;
   logic [DEPTH_LOG2:0]   w_count_next;

   assign w_full       = (r_count == C_DEPTH);
   assign w_valid      = (r_count != C_ZERO);
   assign w_pop        = w_valid & dout_ready;
   assign w_push       = strobe & (~w_full | w_pop);
   assign w_drop       = strobe & w_full & ~w_pop;
   assign w_rd_next    = r_rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, w_pop};
   assign w_after_pop  = r_count - {{DEPTH_LOG2{1'b0}}, w_pop};
   assign w_count_next = w_after_pop + {{DEPTH_LOG2{1'b0}}, w_push};

   // Storage carries no reset; its contents are irrelevant until written.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         // A word pushed into a FIFO that is empty after this cycle's pop becomes the new head,
         // but is not yet in storage, so it is forwarded straight into the output register.
         if (w_push && (w_after_pop == C_ZERO))
            r_dout <= din;
         else if (w_count_next != C_ZERO)
            r_dout <= r_mem[w_rd_next];
         if (w_drop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
      end
   end

`ifdef STROBE_FIFO_OVF_CNT_EN
   logic [7:0] r_ovf_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_cnt <= '0;
      end else if (w_drop && clr_ovf) begin
         r_ovf_cnt <= 8'd1;
      end else if (w_drop) begin
         if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end else if (clr_ovf) begin
         r_ovf_cnt <= '0;
      end
   end

   assign ovf_cnt = r_ovf_cnt;
`endif

   assign dout       = r_dout;
   assign dout_valid = w_valid;
   assign count      = r_count;
   assign full       = w_full;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_strobe_word_fifo.sv
// Directed self-checking bench for strobe_word_fifo (default depth 8, width 8).
module tb_strobe_word_fifo;

   logic       clk;
   logic       rst_n;
   logic       strobe;
   logic [7:0] din;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic [3:0] count;
   logic       full;
   logic       overflow;
   logic       clr_ovf;
`ifdef STROBE_FIFO_OVF_CNT_EN
   logic [7:0] ovf_cnt;
`endif

   int errors = 0;
   int checks = 0;

   strobe_word_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .strobe     (strobe),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
`ifdef STROBE_FIFO_OVF_CNT_EN
      ,
      .ovf_cnt    (ovf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [7:0] base);
      for (int i = 1; i <= 8; i++) begin
         strobe = 1'b1;
         din    = base + 8'(i);
         tick();
      end
      strobe = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; strobe = 1'b0; din = '0; dout_ready = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      check("rst_count", 32'(count), 0);
      check("rst_valid", 32'(dout_valid), 0);
      check("rst_full", 32'(full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_dout", 32'(dout), 0);
`ifdef STROBE_FIFO_OVF_CNT_EN
      check("rst_ovf_cnt", 32'(ovf_cnt), 0);
`endif
      rst_n = 1'b1;
      tick();

      // Single capture latency
      strobe = 1'b1; din = 8'hA5;
      tick();
      strobe = 1'b0;
      check("lat_valid", 32'(dout_valid), 1);
      check("lat_dout", 32'(dout), 32'hA5);
      check("lat_count", 32'(count), 1);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      check("lat_drain_valid", 32'(dout_valid), 0);
      check("lat_drain_count", 32'(count), 0);

      // Fill with 1..8, drain back-to-back
      fill(8'h00);
      check("fill_full", 32'(full), 1);
      check("fill_count", 32'(count), 8);
      dout_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("drain_valid_%0d", k), 32'(dout_valid), 1);
         check($sformatf("drain_dout_%0d", k), 32'(dout), 32'(k));
         tick();
      end
      dout_ready = 1'b0;
      check("drain_empty_valid", 32'(dout_valid), 0);
      check("drain_empty_count", 32'(count), 0);
      check("drain_empty_full", 32'(full), 0);

      // Overflow on full with no pop
      fill(8'h10);
      strobe = 1'b1; din = 8'h99;
      tick();
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_count", 32'(count), 8);
      check("ovf_head", 32'(dout), 32'h11);
`ifdef STROBE_FIFO_OVF_CNT_EN
      check("ovf_cnt1", 32'(ovf_cnt), 1);
`endif
      din = 8'h98;
      tick();
`ifdef STROBE_FIFO_OVF_CNT_EN
      check("ovf_cnt2", 32'(ovf_cnt), 2);
`endif
      // Drop together with clear: drop wins
      din = 8'h55; clr_ovf = 1'b1;
      tick();
      check("clr_drop_flag", 32'(overflow), 1);
`ifdef STROBE_FIFO_OVF_CNT_EN
      check("clr_drop_cnt", 32'(ovf_cnt), 1);
`endif
      strobe = 1'b0;
      tick();
      clr_ovf = 1'b0;
      check("clr_flag", 32'(overflow), 0);
`ifdef STROBE_FIFO_OVF_CNT_EN
      check("clr_cnt", 32'(ovf_cnt), 0);
`endif

      // Full + pop + strobe: word accepted, count stays at depth
      strobe = 1'b1; din = 8'h77; dout_ready = 1'b1;
      tick();
      strobe = 1'b0;
      check("fp_count", 32'(count), 8);
      check("fp_ovf", 32'(overflow), 0);
      for (int k = 2; k <= 9; k++) begin
         check($sformatf("fp_dout_%0d", k), 32'(dout), (k == 9) ? 32'h77 : 32'(8'h10 + 8'(k)));
         tick();
      end
      dout_ready = 1'b0;
      check("fp_empty", 32'(dout_valid), 0);

      // Mid-drain asynchronous reset
      for (int i = 0; i < 3; i++) begin
         strobe = 1'b1; din = 8'hA1 + 8'(i);
         tick();
      end
      strobe = 1'b0; dout_ready = 1'b1;
      tick();
      check("md_dout", 32'(dout), 32'hA2);
      check("md_count", 32'(count), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("md_rst_count", 32'(count), 0);
      check("md_rst_valid", 32'(dout_valid), 0);
      check("md_rst_dout", 32'(dout), 0);
      tick();
      rst_n = 1'b1; dout_ready = 1'b0;
      strobe = 1'b1; din = 8'h3C;
      tick();
      strobe = 1'b0;
      check("post_rst_dout", 32'(dout), 32'h3C);
      check("post_rst_count", 32'(count), 1);
      dout_ready = 1'b1;
      tick();
      check("post_rst_empty", 32'(dout_valid), 0);

      // Empty: strobe with dout_ready is a push, no pop
      strobe = 1'b1; din = 8'h5A;
      tick();
      strobe = 1'b0; dout_ready = 1'b0;
      check("er_count", 32'(count), 1);
      check("er_dout", 32'(dout), 32'h5A);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      check("er_drain", 32'(count), 0);

`ifdef STROBE_FIFO_OVF_CNT_EN
      // Counter saturation
      fill(8'h40);
      strobe = 1'b1; din = 8'hEE;
      for (int i = 0; i < 260; i++) tick();
      strobe = 1'b0;
      check("sat_cnt", 32'(ovf_cnt), 255);
      check("sat_head", 32'(dout), 32'h41);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
